// File: rtl/sbox_lane_pipe.sv
// rtl/sbox_lane_pipe.sv - pipelined multi-lane AES forward/inverse S-box with valid/ready backpressure
module sbox_lane_pipe #(
    parameter int LANES  = 16,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               inValid,
    output logic               inReady,
    input  logic               inInverse,
    input  logic [8*LANES-1:0] inData,
    output logic               outValid,
    input  logic               outReady,
    output logic [8*LANES-1:0] outData,
    output logic               outInverse,
    output logic [2:0]         occupancy
);

    localparam int W = 8 * LANES;

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("sbox_lane_pipe: LANES must be within 1..16");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("sbox_lane_pipe: STAGES must be within 1..4");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    logic [W-1:0]      sub_data;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_inv;
    logic [W-1:0]      stage_data [STAGES];
    logic [STAGES-1:0] adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub_data[8*i +: 8] = inInverse ? inv_sbox(inData[8*i +: 8])
                                              : fwd_sbox(inData[8*i +: 8]);
    end

    // Stage k can move when any stage at or after k is empty, or the output drains
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & stage_valid[k];
            adv[k]    = outReady | ~full_tail;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stage_valid <= '0;
            stage_inv   <= '0;
            for (int k = 0; k < STAGES; k++) stage_data[k] <= '0;
        end else begin
            if (adv[0]) begin
                stage_valid[0] <= inValid;
                if (inValid) begin
                    stage_inv[0]  <= inInverse;
                    stage_data[0] <= sub_data;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    stage_valid[k] <= stage_valid[k-1];
                    if (stage_valid[k-1]) begin
                        stage_inv[k]  <= stage_inv[k-1];
                        stage_data[k] <= stage_data[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = 3'd0;
        for (int k = 0; k < STAGES; k++) occupancy = occupancy + 3'(stage_valid[k]);
    end

    assign inReady    = adv[0];
    assign outValid   = stage_valid[STAGES-1];
    assign outData    = stage_data[STAGES-1];
    assign outInverse = stage_inv[STAGES-1];

endmodule
